// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory read in flight, and
// buffers returned words with their PC in a small FIFO whose head feeds IF/ID.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        id_LE,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   entry_instr_q [DEPTH];
    logic [31:0]   entry_pc_q    [DEPTH];

    logic space;
    logic issue;
    logic push;
    logic pop;

    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? entry_instr_q[rd_ptr_q] : NOP;
    assign pc_out      = instr_valid ? entry_pc_q[rd_ptr_q] : 32'h0;
    assign pc4_out     = instr_valid ? entry_pc_q[rd_ptr_q] + 32'd4 : 32'h0;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        // An in-flight read already owns a slot, so it counts against the space check.
        space = ({1'b0, count_q} + {{(AW + 1){1'b0}}, (state_q != S_FETCH)}) < (AW + 2)'(DEPTH);
        issue = !Reset && !redirect && space &&
                ((state_q == S_FETCH) || ((state_q == S_WAIT) && imem_rvalid));
        push  = !redirect && (state_q == S_WAIT) && imem_rvalid;
        pop   = !redirect && instr_valid && id_LE;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_target & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            state_d    = ((state_q != S_FETCH) && !imem_rvalid) ? S_DISCARD : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH:   state_d = issue ? S_WAIT : S_FETCH;
                S_WAIT:    state_d = (imem_rvalid && !issue) ? S_FETCH : S_WAIT;
                S_DISCARD: state_d = imem_rvalid ? S_FETCH : S_DISCARD;
                default:   state_d = S_FETCH;
            endcase

            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry contents need no reset: they are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !Reset) begin
            entry_instr_q[wr_ptr_q] <= imem_rdata;
            entry_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every cycle, plus
// directed scenarios pinned with hand-computed literal expectations.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, rv, redir, le;
    logic [31:0] rd, tgt;
    logic        req, valid;
    logic [31:0] addr, instr, pc, pc4;

    logic        rst2, rv2;
    logic [31:0] rd2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2, pc42;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOPW)) dut (
        .clk(clk), .Reset(rst), .imem_req(req), .imem_addr(addr),
        .imem_rvalid(rv), .imem_rdata(rd), .redirect(redir), .redirect_target(tgt),
        .id_LE(le), .instr_valid(valid), .instr_out(instr), .pc_out(pc), .pc4_out(pc4)
    );

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .NOP(NOPW)) dut2 (
        .clk(clk), .Reset(rst2), .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rv2), .imem_rdata(rd2), .redirect(1'b0), .redirect_target(32'h0),
        .id_LE(1'b1), .instr_valid(valid2), .instr_out(instr2), .pc_out(pc2), .pc4_out(pc42)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_req_pc;
    bit          m_inflight, m_keep;

    bit          mem_busy;
    int          mem_due;
    logic [31:0] mem_addr;
    int          lat;
    int          cyc;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check DUT against the model, advance model and memory.
    task automatic step(input bit r, input bit rdir, input logic [31:0] t, input bit l);
        bit          e_valid, e_space, e_req;
        logic [31:0] e_instr, e_pc, e_pc4;
        @(negedge clk);
        rst   = r;
        redir = rdir;
        tgt   = t;
        le    = l;
        rv    = mem_busy && (cyc == mem_due);
        rd    = rv ? mem_addr + 32'h100 : 32'hDEAD_BEEF;
        #1;
        s_req = req; s_addr = addr; s_valid = valid;
        s_instr = instr; s_pc = pc; s_pc4 = pc4;
        if (r) begin
            chk("req_in_reset", {31'b0, s_req}, 32'h0);
            mq.delete();
            m_pc       = 32'h0;
            m_inflight = 0;
            m_keep     = 0;
        end else begin
            e_valid = (mq.size() > 0);
            e_instr = e_valid ? mq[0].instr : NOPW;
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_pc4   = e_valid ? mq[0].pc + 32'd4 : 32'h0;
            e_space = (mq.size() + (m_inflight ? 1 : 0)) < DEPTH;
            e_req   = !rdir && e_space && (!m_inflight || (m_keep && rv));
            chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
            if (e_req) chk("imem_addr", s_addr, m_pc);
            chk("instr_valid", {31'b0, s_valid}, {31'b0, e_valid});
            chk("instr_out", s_instr, e_instr);
            chk("pc_out", s_pc, e_pc);
            chk("pc4_out", s_pc4, e_pc4);
            if (rdir) begin
                mq.delete();
                m_pc = t & ~32'h3;
                if (m_inflight && !rv) m_keep = 0;
                else m_inflight = 0;
            end else begin
                if (e_valid && l) void'(mq.pop_front());
                if (m_inflight && rv) begin
                    if (m_keep) mq.push_back('{instr: rd, pc: m_req_pc});
                    m_inflight = 0;
                end
                if (e_req) begin
                    m_inflight = 1;
                    m_keep     = 1;
                    m_req_pc   = m_pc;
                    m_pc       = m_pc + 32'd4;
                end
            end
        end
        if (rv) mem_busy = 0;
        if (s_req) begin
            mem_busy = 1;
            mem_due  = cyc + lat;
            mem_addr = s_addr;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          nreq;
        bit          found;
        logic [31:0] a2 [3];
        int          na2;
        logic        p_req;
        logic [31:0] p_addr;
        logic [31:0] w_pc4, w_instr;

        rst = 1; rv = 0; redir = 0; le = 0; rd = 0; tgt = 0;
        rst2 = 1; rv2 = 0; rd2 = 0;
        vectors = 0; miscompares = 0; cyc = 0; mem_busy = 0; mem_due = 0;
        mem_addr = 0; m_pc = 0; m_req_pc = 0; m_inflight = 0; m_keep = 0;

        // 1: 1-cycle memory, id_LE held high
        lat = 1;
        do_reset(2);
        chk("t1_reset_valid", {31'b0, s_valid}, 32'h0);
        chk("t1_reset_instr", s_instr, 32'h13);
        chk("t1_reset_pc", s_pc, 32'h0);
        chk("t1_reset_pc4", s_pc4, 32'h0);
        step(0, 0, 0, 1);
        chk("t1_addr0", s_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("t1_addr4", s_addr, 32'h4);
        step(0, 0, 0, 1);
        chk("t1_addr8", s_addr, 32'h8);
        chk("t1_instr0", s_instr, 32'h100);
        chk("t1_pc0", s_pc, 32'h0);
        chk("t1_pc4_0", s_pc4, 32'h4);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1);
            chk("t1_stream_instr", s_instr, 32'h100 + 32'(4 * k));
            chk("t1_stream_pc", s_pc, 32'(4 * k));
        end

        // 2: id_LE low fills the FIFO; one pop frees exactly one read
        do_reset(4);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (s_req) nreq++;
        end
        chk("t2_reads_when_full", 32'(nreq), 32'd4);
        chk("t2_valid", {31'b0, s_valid}, 32'h1);
        chk("t2_head", s_instr, 32'h100);
        step(0, 0, 0, 1);
        nreq = 0;
        p_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0);
            if (s_req) begin
                nreq++;
                p_addr = s_addr;
            end
        end
        chk("t2_reads_after_pop", 32'(nreq), 32'd1);
        chk("t2_fifth_addr", p_addr, 32'h10);

        // 3: redirect while a 3-cycle read of addr 8 is in flight
        lat = 3;
        do_reset(4);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0, 1);
            if (s_req && s_addr == 32'h8) found = 1;
        end
        chk("t3_reached_addr8", {31'b0, found}, 32'h1);
        step(0, 0, 0, 1);
        step(0, 1, 32'h203, 1);
        step(0, 0, 0, 1);
        chk("t3_flushed", {31'b0, s_valid}, 32'h0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (i > 0) step(0, 0, 0, 1);
            if (s_req) found = 1;
        end
        chk("t3_req_seen", {31'b0, found}, 32'h1);
        chk("t3_target_addr", s_addr, 32'h200);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0, 1);
            if (s_valid) found = 1;
        end
        chk("t3_valid_seen", {31'b0, found}, 32'h1);
        chk("t3_first_pc", s_pc, 32'h200);

        // 4: redirect in the same cycle as imem_rvalid
        lat = 2;
        do_reset(4);
        step(0, 0, 0, 1);
        for (int i = 0; i < 10 && !(mem_busy && cyc == mem_due); i++) step(0, 0, 0, 1);
        chk("t4_rvalid_due", {31'b0, (mem_busy && cyc == mem_due)}, 32'h1);
        step(0, 1, 32'h400, 1);
        step(0, 0, 0, 1);
        chk("t4_req_next", {31'b0, s_req}, 32'h1);
        chk("t4_addr_target", s_addr, 32'h400);

        // 5: reset while a read is outstanding; its late data must not land
        lat = 3;
        do_reset(4);
        step(0, 0, 0, 1);
        chk("t5_issue", {31'b0, s_req}, 32'h1);
        do_reset(3);
        step(0, 0, 0, 1);
        chk("t5_no_push", {31'b0, s_valid}, 32'h0);
        chk("t5_restart_addr", s_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("t5_still_empty", {31'b0, s_valid}, 32'h0);

        // 6: PC wrap from RESET_PC=FFFFFFF8 on the second instance
        rst = 1;
        @(negedge clk); rst2 = 1;
        @(negedge clk); rst2 = 1;
        p_req = 0; p_addr = 0; na2 = 0; found = 0; w_pc4 = 32'hFFFF_FFFF; w_instr = 0;
        for (int i = 0; i < 3; i++) a2[i] = 32'h1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst2 = 0;
            rv2  = p_req;
            rd2  = p_addr + 32'h100;
            #1;
            if (req2 && na2 < 3) begin
                a2[na2] = addr2;
                na2++;
            end
            if (valid2 && pc2 == 32'hFFFF_FFFC && !found) begin
                found   = 1;
                w_pc4   = pc42;
                w_instr = instr2;
            end
            p_req  = req2;
            p_addr = addr2;
        end
        chk("t6_addr0", a2[0], 32'hFFFF_FFF8);
        chk("t6_addr1", a2[1], 32'hFFFF_FFFC);
        chk("t6_addr2", a2[2], 32'h0);
        chk("t6_entry_seen", {31'b0, found}, 32'h1);
        chk("t6_wrap_pc4", w_pc4, 32'h0);
        chk("t6_wrap_instr", w_instr, 32'h0000_00FC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
